lu_shared_sequencer: RTL and testbench
======================================

Name: lu_shared_sequencer

Overview:
Controller that shares one selectable 1-bit logic unit (AND/OR/NAND/NOR, selected by chave1/chave2) between two requesters. It arbitrates round-robin and registers the operands and opcode onto the unit's inputs. It then waits a programmable settle time, samples the unit's result and returns it to the winning requester as a one-cycle response. It sits between requester blocks and the external logic-unit instance.

Parameters:
SETTLE_CYCLES, 1, cycles lu_* inputs are held before lu_result is sampled; legal range 1..15, 0 is treated as 1
CNT_W, 4, width of the internal settle counter; must hold SETTLE_CYCLES

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  reset, synchronous, active-low
req0_valid  in  1  requester 0 has a request; held until accepted
req0_a  in  1  operand a, requester 0
req0_b  in  1  operand b, requester 0
req0_op  in  2  opcode {chave1,chave2}: 00 AND, 01 OR, 10 NAND, 11 NOR
req0_ready  out  1  accept strobe, requester 0 (combinational)
rsp0_valid  out  1  one-cycle response pulse, requester 0
rsp0_result  out  1  result for requester 0; valid while rsp0_valid
req1_valid, req1_a, req1_b, req1_op, req1_ready, rsp1_valid, rsp1_result  same as above for requester 1
lu_a  out  1  registered operand a to the logic unit
lu_b  out  1  registered operand b to the logic unit
lu_chave1  out  1  registered op[1] to the logic unit
lu_chave2  out  1  registered op[0] to the logic unit
lu_result  in  1  logic-unit output
busy  out  1  high whenever the state is not IDLE
grant_id  out  1  requester of the current or most recent transaction

Behaviour:
- Reset (rst_n low at a rising edge): state=IDLE; lu_a, lu_b, lu_chave1, lu_chave2, rsp*_valid, rsp*_result, busy, grant_id = 0; last_grant=1, so requester 0 wins first. Any in-flight transaction is dropped and produces no response.
- FSM states:
  - IDLE -> DRIVE on accept.
  - DRIVE: counter loaded with SETTLE_CYCLES-1 on entry and decremented each cycle; -> RESP when the counter is 0, with lu_result sampled at that edge.
  - RESP: lasts 1 cycle -> IDLE.
- Arbitration, IDLE only:
  - Only req0_valid: grant 0.
  - Only req1_valid: grant 1.
  - Both valid: grant the id != last_grant.
  - reqN_ready = (state==IDLE) & reqN_valid & granted(N). Never both high; always 0 outside IDLE.
- On accept (cycle T):
  - lu_a, lu_b, lu_chave1, lu_chave2 load the granted operands at the T edge; visible from T+1.
  - grant_id and last_grant <= granted id.
- lu_* hold their values through DRIVE and RESP and after it; they change only on the next accept or on reset.
- Sampling and response:
  - lu_result is sampled at the edge ending cycle T+SETTLE_CYCLES.
  - rsp{grant_id}_valid=1 with rsp_result=sample during cycle T+SETTLE_CYCLES+1 (RESP).
  - The other requester's rsp_valid stays 0.
  - rsp*_result holds its last value after the pulse.
- Latency: accept to response = SETTLE_CYCLES+1 cycles. Next accept earliest at T+SETTLE_CYCLES+2.
- Throughput: one transaction per SETTLE_CYCLES+2 cycles.
- busy: high from T+1 through RESP inclusive.
- Requester dropping valid before ready: no accept, no state change. Operand changes while valid is held are allowed; the values present in the accept cycle are used.
- No response back-pressure; rsp is a fire-and-forget pulse.
- Reset mid-DRIVE or mid-RESP: reset wins. No rsp pulse in the following cycle; the next request is served normally.

Test Plan:
- Reset: rst_n=0 for 2 edges with req0_valid=1 -> all outputs 0 and req0_ready=0 during reset. After release req0_ready=1 in the first cycle (first grant to 0).
- Single OR (SETTLE_CYCLES=1, combinational LU model): req0 a=1,b=0,op=01 accepted at T -> lu_a=1, lu_b=0, lu_chave1=0, lu_chave2=1 at T+1. rsp0_valid=1 with rsp0_result=1 at T+2; busy=1 at T+1..T+2; rsp1_valid=0 throughout.
- Exhaustive sweep via req1, all 16 (a,b,op) with (a,b) ordered 00,01,10,11 -> results AND 0001, OR 0111, NAND 1110, NOR 1000; grant_id=1 for every transaction.
- Contention: both valid continuously (SETTLE_CYCLES=1) -> grants 0,1,0,1,... with an accept every 3 cycles and each response routed only to its grant_id.
- Reset mid-operation: rst_n=0 during DRIVE -> no rsp pulse, busy=0, lu_*=0. A following req0 AND a=1,b=1 completes with rsp0_result=1.
- Settle: SETTLE_CYCLES=3 with the LU model delaying lu_result by 2 cycles; NAND a=1,b=1 accepted at T -> rsp at T+4, result 0, and no rsp at T+2 or T+3.

Source files
------------

// File: rtl/lu_shared_sequencer.sv
// Round-robin sequencer sharing one external 1-bit logic unit (AND/OR/NAND/NOR) between two
// requesters: registers the winner's operands onto the unit, waits a settle time, returns the result.
module lu_shared_sequencer #(
  parameter int unsigned SETTLE_CYCLES = 1,
  parameter int unsigned CNT_W         = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0_valid,
  input  logic       req0_a,
  input  logic       req0_b,
  input  logic [1:0] req0_op,
  output logic       req0_ready,
  output logic       rsp0_valid,
  output logic       rsp0_result,
  input  logic       req1_valid,
  input  logic       req1_a,
  input  logic       req1_b,
  input  logic [1:0] req1_op,
  output logic       req1_ready,
  output logic       rsp1_valid,
  output logic       rsp1_result,
  output logic       lu_a,
  output logic       lu_b,
  output logic       lu_chave1,
  output logic       lu_chave2,
  input  logic       lu_result,
  output logic       busy,
  output logic       grant_id
);

  localparam int unsigned SETTLE_EFF = (SETTLE_CYCLES == 0) ? 1 : SETTLE_CYCLES;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_EFF - 1);

  typedef enum logic [1:0] {IDLE, DRIVE, RESP} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             lu_a_q, lu_a_d, lu_b_q, lu_b_d;
  logic             lu_c1_q, lu_c1_d, lu_c2_q, lu_c2_d;
  logic             grant_id_q, grant_id_d, last_grant_q, last_grant_d;
  logic             rsp0_valid_q, rsp0_valid_d, rsp1_valid_q, rsp1_valid_d;
  logic             rsp0_result_q, rsp0_result_d, rsp1_result_q, rsp1_result_d;

  logic             grant;
  logic             accept;
  logic [1:0]       op_sel;

  // Contention goes to whoever did not win last time; a lone requester always wins.
  always_comb begin
    grant = 1'b0;
    if (req0_valid && req1_valid) grant = ~last_grant_q;
    else if (req1_valid)          grant = 1'b1;
  end

  // Gated by rst_n so neither requester sees a strobe while reset is asserted.
  assign accept     = rst_n && (state_q == IDLE) && (req0_valid || req1_valid);
  assign req0_ready = accept && !grant;
  assign req1_ready = accept && grant;
  assign op_sel     = grant ? req1_op : req0_op;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    lu_a_d        = lu_a_q;
    lu_b_d        = lu_b_q;
    lu_c1_d       = lu_c1_q;
    lu_c2_d       = lu_c2_q;
    grant_id_d    = grant_id_q;
    last_grant_d  = last_grant_q;
    rsp0_valid_d  = 1'b0;
    rsp1_valid_d  = 1'b0;
    rsp0_result_d = rsp0_result_q;
    rsp1_result_d = rsp1_result_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d      = DRIVE;
          cnt_d        = CNT_LOAD;
          lu_a_d       = grant ? req1_a : req0_a;
          lu_b_d       = grant ? req1_b : req0_b;
          lu_c1_d      = op_sel[1];
          lu_c2_d      = op_sel[0];
          grant_id_d   = grant;
          last_grant_d = grant;
        end
      end
      DRIVE: begin
        if (cnt_q == '0) begin
          state_d = RESP;
          if (grant_id_q) begin
            rsp1_valid_d  = 1'b1;
            rsp1_result_d = lu_result;
          end else begin
            rsp0_valid_d  = 1'b1;
            rsp0_result_d = lu_result;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      lu_a_q        <= 1'b0;
      lu_b_q        <= 1'b0;
      lu_c1_q       <= 1'b0;
      lu_c2_q       <= 1'b0;
      grant_id_q    <= 1'b0;
      last_grant_q  <= 1'b1;
      rsp0_valid_q  <= 1'b0;
      rsp1_valid_q  <= 1'b0;
      rsp0_result_q <= 1'b0;
      rsp1_result_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      lu_a_q        <= lu_a_d;
      lu_b_q        <= lu_b_d;
      lu_c1_q       <= lu_c1_d;
      lu_c2_q       <= lu_c2_d;
      grant_id_q    <= grant_id_d;
      last_grant_q  <= last_grant_d;
      rsp0_valid_q  <= rsp0_valid_d;
      rsp1_valid_q  <= rsp1_valid_d;
      rsp0_result_q <= rsp0_result_d;
      rsp1_result_q <= rsp1_result_d;
    end
  end

  assign lu_a        = lu_a_q;
  assign lu_b        = lu_b_q;
  assign lu_chave1   = lu_c1_q;
  assign lu_chave2   = lu_c2_q;
  assign grant_id    = grant_id_q;
  assign rsp0_valid  = rsp0_valid_q;
  assign rsp1_valid  = rsp1_valid_q;
  assign rsp0_result = rsp0_result_q;
  assign rsp1_result = rsp1_result_q;
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_lu_shared_sequencer.sv
// Self-checking bench: a cycle-numbered transaction model checks a SETTLE_CYCLES=1 instance every
// cycle; a SETTLE_CYCLES=3 instance with a 2-cycle-late logic unit covers the settle wait.
module tb_lu_shared_sequencer;

  localparam int S1 = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       req0_valid, req0_a, req0_b, req0_ready, rsp0_valid, rsp0_result;
  logic       req1_valid, req1_a, req1_b, req1_ready, rsp1_valid, rsp1_result;
  logic [1:0] req0_op, req1_op;
  logic       lu_a, lu_b, lu_chave1, lu_chave2, lu_result, busy, grant_id;

  logic       r3_rst_n, r3_v, r3_a, r3_b, r3_ready0, r3_rsp0_valid, r3_rsp0_result;
  logic [1:0] r3_op;
  logic       r3_ready1, r3_rsp1_valid, r3_rsp1_result;
  logic       r3_lu_a, r3_lu_b, r3_lu_c1, r3_lu_c2, r3_lu_result, r3_busy, r3_gid;
  logic       r3_d1, r3_d2;
  logic       zero1;
  logic [1:0] zero2;

  function automatic logic lu_fn(input logic a, input logic b, input logic [1:0] op);
    logic r;
    case (op)
      2'b00:   r = a & b;
      2'b01:   r = a | b;
      2'b10:   r = ~(a & b);
      default: r = ~(a | b);
    endcase
    return r;
  endfunction

  assign lu_result = lu_fn(lu_a, lu_b, {lu_chave1, lu_chave2});

  // Slow logic unit for the settle instance: result lags its inputs by two cycles.
  always_ff @(posedge clk) begin
    r3_d1 <= lu_fn(r3_lu_a, r3_lu_b, {r3_lu_c1, r3_lu_c2});
    r3_d2 <= r3_d1;
  end
  assign r3_lu_result = r3_d2;

  lu_shared_sequencer #(.SETTLE_CYCLES(S1), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req0_ready(req0_ready), .rsp0_valid(rsp0_valid), .rsp0_result(rsp0_result),
    .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .req1_ready(req1_ready), .rsp1_valid(rsp1_valid), .rsp1_result(rsp1_result),
    .lu_a(lu_a), .lu_b(lu_b), .lu_chave1(lu_chave1), .lu_chave2(lu_chave2),
    .lu_result(lu_result), .busy(busy), .grant_id(grant_id)
  );

  lu_shared_sequencer #(.SETTLE_CYCLES(3), .CNT_W(4)) dut3 (
    .clk(clk), .rst_n(r3_rst_n),
    .req0_valid(r3_v), .req0_a(r3_a), .req0_b(r3_b), .req0_op(r3_op),
    .req0_ready(r3_ready0), .rsp0_valid(r3_rsp0_valid), .rsp0_result(r3_rsp0_result),
    .req1_valid(zero1), .req1_a(zero1), .req1_b(zero1), .req1_op(zero2),
    .req1_ready(r3_ready1), .rsp1_valid(r3_rsp1_valid), .rsp1_result(r3_rsp1_result),
    .lu_a(r3_lu_a), .lu_b(r3_lu_b), .lu_chave1(r3_lu_c1), .lu_chave2(r3_lu_c2),
    .lu_result(r3_lu_result), .busy(r3_busy), .grant_id(r3_gid)
  );

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  // Transaction model: the unit is free from cycle m_free on; one pending response at most.
  int       m_free, m_rsp_cyc;
  logic     m_rsp_id, m_rsp_res, m_last, m_gid, m_res0, m_res1;
  logic [3:0] m_lu;

  typedef struct {
    logic       a;
    logic       b;
    logic [1:0] op;
    logic       exp;
  } vec_t;
  vec_t tbl[16];

  task automatic chk(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d actual=%b required=%b", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    m_free = 0; m_rsp_cyc = -1; m_last = 1'b1; m_gid = 1'b0;
    m_lu = 4'b0; m_res0 = 1'b0; m_res1 = 1'b0;
  endtask

  task automatic chk_now();
    logic idle, g, acc, rv0, rv1;
    @(negedge clk);
    idle = (cyc >= m_free);
    rv0 = 1'b0; rv1 = 1'b0;
    if (cyc == m_rsp_cyc) begin
      if (m_rsp_id) begin rv1 = 1'b1; m_res1 = m_rsp_res; end
      else          begin rv0 = 1'b1; m_res0 = m_rsp_res; end
    end
    g   = (req0_valid && req1_valid) ? ~m_last : req1_valid;
    acc = rst_n && idle && (req0_valid || req1_valid);
    chk("ready0", req0_ready, acc && !g);
    chk("ready1", req1_ready, acc && g);
    chk("busy", busy, !idle);
    chk("rsp0_valid", rsp0_valid, rv0);
    chk("rsp1_valid", rsp1_valid, rv1);
    chk("rsp0_result", rsp0_result, m_res0);
    chk("rsp1_result", rsp1_result, m_res1);
    chk("lu_a", lu_a, m_lu[3]);
    chk("lu_b", lu_b, m_lu[2]);
    chk("lu_chave1", lu_chave1, m_lu[1]);
    chk("lu_chave2", lu_chave2, m_lu[0]);
    chk("grant_id", grant_id, m_gid);
    if (!rst_n) model_reset();
    else if (acc) begin
      m_last    = g;
      m_gid     = g;
      m_lu      = g ? {req1_a, req1_b, req1_op} : {req0_a, req0_b, req0_op};
      m_rsp_cyc = cyc + S1 + 1;
      m_rsp_id  = g;
      m_rsp_res = lu_fn(m_lu[3], m_lu[2], m_lu[1:0]);
      m_free    = cyc + S1 + 2;
    end
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    logic [15:0] exp_bits;
    logic [1:0]  s3_ab [2];
    logic        s3_exp [2];
    exp_bits = 16'b0001_0111_1110_1000;
    for (int i = 0; i < 16; i++) begin
      tbl[i].op  = 2'(i / 4);
      tbl[i].a   = 1'(i / 2);
      tbl[i].b   = 1'(i);
      tbl[i].exp = exp_bits[15 - i];
    end
    s3_ab[0] = 2'b00; s3_exp[0] = 1'b1;
    s3_ab[1] = 2'b11; s3_exp[1] = 1'b0;

    zero1 = 1'b0; zero2 = 2'b00;
    r3_rst_n = 1'b0; r3_v = 1'b0; r3_a = 1'b0; r3_b = 1'b0; r3_op = 2'b00;
    rst_n = 1'b0;
    req0_valid = 1'b1; req0_a = 1'b1; req0_b = 1'b0; req0_op = 2'b01;
    req1_valid = 1'b0; req1_a = 1'b0; req1_b = 1'b0; req1_op = 2'b00;
    @(posedge clk); #1;
    model_reset();

    // second reset edge, request already pending
    chk_now();
    chk("rst_ready0", req0_ready, 1'b0);
    chk("rst_busy", busy, 1'b0);
    adv();
    rst_n = 1'b1;

    // single OR from requester 0, first grant
    chk_now(); chk("or_ready0", req0_ready, 1'b1); adv();
    req0_valid = 1'b0;
    chk_now();
    chk("or_lu_a", lu_a, 1'b1); chk("or_lu_b", lu_b, 1'b0);
    chk("or_chave1", lu_chave1, 1'b0); chk("or_chave2", lu_chave2, 1'b1);
    chk("or_busy1", busy, 1'b1);
    adv();
    chk_now();
    chk("or_rsp0", rsp0_valid, 1'b1); chk("or_res0", rsp0_result, 1'b1);
    chk("or_rsp1", rsp1_valid, 1'b0); chk("or_busy2", busy, 1'b1);
    adv();
    chk_now(); chk("or_idle", busy, 1'b0); adv();

    // exhaustive sweep via requester 1
    for (int i = 0; i < 16; i++) begin
      req1_valid = 1'b1; req1_a = tbl[i].a; req1_b = tbl[i].b; req1_op = tbl[i].op;
      chk_now(); chk("sweep_ready1", req1_ready, 1'b1); adv();
      req1_valid = 1'b0;
      chk_now(); adv();
      chk_now();
      chk("sweep_rsp1", rsp1_valid, 1'b1);
      chk("sweep_res", rsp1_result, tbl[i].exp);
      chk("sweep_gid", grant_id, 1'b1);
      adv();
    end

    // contention: both requesting continuously, accepts every 3 cycles, alternating from 0
    req0_valid = 1'b1; req1_valid = 1'b1;
    for (int k = 0; k < 12; k++) begin
      req0_a = 1'($urandom); req0_b = 1'($urandom); req0_op = 2'($urandom);
      req1_a = 1'($urandom); req1_b = 1'($urandom); req1_op = 2'($urandom);
      chk_now();
      if (k % 3 == 0) begin
        chk("cont_ready0", req0_ready, (k % 6) == 0);
        chk("cont_ready1", req1_ready, (k % 6) == 3);
      end
      adv();
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin chk_now(); adv(); end

    // reset during DRIVE drops the transaction
    req1_valid = 1'b1; req1_a = 1'b1; req1_b = 1'b1; req1_op = 2'b11;
    chk_now(); adv();
    req1_valid = 1'b0; rst_n = 1'b0;
    chk_now(); adv();
    rst_n = 1'b1;
    chk_now();
    chk("rmid_rsp1", rsp1_valid, 1'b0); chk("rmid_rsp0", rsp0_valid, 1'b0);
    chk("rmid_busy", busy, 1'b0); chk("rmid_lu_a", lu_a, 1'b0);
    chk("rmid_lu_chave1", lu_chave1, 1'b0);
    adv();
    req0_valid = 1'b1; req0_a = 1'b1; req0_b = 1'b1; req0_op = 2'b00;
    chk_now(); chk("rmid_ready0", req0_ready, 1'b1); adv();
    req0_valid = 1'b0;
    chk_now(); adv();
    chk_now(); chk("rmid_rsp0_after", rsp0_valid, 1'b1); chk("rmid_res0", rsp0_result, 1'b1); adv();

    // randomized traffic with occasional resets
    for (int k = 0; k < 600; k++) begin
      rst_n      = ($urandom_range(0, 39) != 0);
      req0_valid = 1'($urandom); req0_a = 1'($urandom); req0_b = 1'($urandom); req0_op = 2'($urandom);
      req1_valid = 1'($urandom); req1_a = 1'($urandom); req1_b = 1'($urandom); req1_op = 2'($urandom);
      chk_now(); adv();
    end
    rst_n = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin chk_now(); adv(); end

    // settle instance: SETTLE_CYCLES=3 against a 2-cycle-late unit
    chk_now(); adv();
    r3_rst_n = 1'b1;
    chk_now(); chk("s3_idle", r3_busy, 1'b0); adv();
    for (int t = 0; t < 2; t++) begin
      r3_v = 1'b1; r3_a = s3_ab[t][1]; r3_b = s3_ab[t][0]; r3_op = 2'b10;
      chk_now(); chk("s3_ready", r3_ready0, 1'b1); adv();
      r3_v = 1'b0;
      for (int d = 1; d <= 4; d++) begin
        chk_now();
        chk("s3_rsp_valid", r3_rsp0_valid, d == 4);
        if (d == 4) chk("s3_rsp_res", r3_rsp0_result, s3_exp[t]);
        chk("s3_busy", r3_busy, 1'b1);
        chk("s3_rsp1", r3_rsp1_valid, 1'b0);
        adv();
      end
      chk_now(); chk("s3_busy_end", r3_busy, 1'b0); adv();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
